// File: rtl/bus_pkg.sv
// Shared types for the bus arbiter slice: slave/master ids and arbiter FSM states.
package bus_pkg;

   localparam int unsigned SLAVE_ID_W = 2;

   typedef logic [SLAVE_ID_W-1:0] slave_t;
   typedef logic [3:0]            master_t;

   typedef enum logic [1:0] {IDLE, GRANT, HOLD, GAP} arb_state_t;

   // A slave id addresses a real slave only in the range 1..n_slaves.
   function automatic logic slave_ok(input slave_t id, input int unsigned n_slaves);
      return (id != '0) && (32'(id) <= n_slaves);
   endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first valid entry at or after ptr, wrapping.
module rr_select #(
   parameter int unsigned N = 2,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   always_comb begin
      int unsigned j;
      found = |valid;
      idx   = ptr;
      j     = 0;
      // Scan from the farthest offset back to ptr so the nearest hit wins.
      for (int unsigned k = N; k > 0; k--) begin
         j = (32'(ptr) + k - 1) % N;
         if (valid[W'(j)])
            idx = W'(j);
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold watchdog and fixed handover gap between owners.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned INT_MASTER_COUNT   = 2,
   parameter int unsigned INT_SLAVE_COUNT    = 3,
   parameter int unsigned FIRST_START_MASTER = 0,
   parameter int unsigned HOLD_TIMEOUT       = 4096,
   parameter int unsigned HANDOVER_GAP       = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [INT_MASTER_COUNT-1:0]         req,
   input  logic [2*INT_MASTER_COUNT-1:0]       slave_id,
   input  logic [INT_MASTER_COUNT-1:0]         done,
   output logic [INT_MASTER_COUNT-1:0]         grant,
   output logic [$clog2(INT_MASTER_COUNT)-1:0] grant_id,
   output logic [INT_SLAVE_COUNT-1:0]          slave_sel,
   output logic                                bus_busy,
   output logic                                timeout_err
);

   localparam int unsigned MW = $clog2(INT_MASTER_COUNT);
   localparam int unsigned CW = $clog2(HOLD_TIMEOUT) + 1;
   localparam int unsigned GW = $clog2(HANDOVER_GAP) + 1;

   arb_state_t                  state;
   logic [MW-1:0]               ptr;
   logic [CW-1:0]               wd_cnt;
   logic [GW-1:0]               gap_cnt;
   logic [INT_MASTER_COUNT-1:0] valid;
   logic                        found;
   logic [MW-1:0]               pick;
   slave_t                      pick_id;
   logic [INT_SLAVE_COUNT-1:0]  sel_dec;
   logic                        owner_done;
   logic                        owner_req;
   logic                        wd_expired;
   logic [MW-1:0]               next_ptr;

   always_comb begin
      valid = '0;
      for (int unsigned i = 0; i < INT_MASTER_COUNT; i++)
         valid[i] = req[i] && slave_ok(slave_id[i*SLAVE_ID_W +: SLAVE_ID_W], INT_SLAVE_COUNT);
   end

   rr_select #(
      .N (INT_MASTER_COUNT),
      .W (MW)
   ) u_rr_select (
      .valid (valid),
      .ptr   (ptr),
      .found (found),
      .idx   (pick)
   );

   always_comb begin
      pick_id = slave_id[32'(pick)*SLAVE_ID_W +: SLAVE_ID_W];
      sel_dec = '0;
      for (int unsigned s = 0; s < INT_SLAVE_COUNT; s++)
         sel_dec[s] = (pick_id == slave_t'(s + 1));
   end

   assign owner_done = done[grant_id];
   assign owner_req  = req[grant_id];
   assign wd_expired = (wd_cnt == CW'(HOLD_TIMEOUT - 1));
   assign next_ptr   = (grant_id == MW'(INT_MASTER_COUNT - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= MW'(FIRST_START_MASTER);
         wd_cnt      <= '0;
         gap_cnt     <= '0;
         grant       <= '0;
         grant_id    <= '0;
         slave_sel   <= '0;
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant     <= INT_MASTER_COUNT'(1) << pick;
                  grant_id  <= pick;
                  slave_sel <= sel_dec;
                  bus_busy  <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               wd_cnt <= '0;
               state  <= HOLD;
            end
            HOLD: begin
               if (owner_done || !owner_req || wd_expired) begin
                  grant       <= '0;
                  slave_sel   <= '0;
                  timeout_err <= wd_expired && owner_req && !owner_done;
                  ptr         <= next_ptr;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(HANDOVER_GAP - 1)) begin
                  bus_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
